mem_access_unit: RTL and testbench

MEM-stage data-memory access unit of the pipelined RV32 core. It sits directly downstream of the MEM-stage store-data forwarding logic and consumes the forwarded store operand. It runs a request/ready handshake to the data-memory bus and aligns store data onto byte lanes. It extracts and sign- or zero-extends load data and registers the result as the MEM/WB load value that feeds WB and the MEM→MEM forwarding path. It stalls the pipeline while a bus access is outstanding.

---
 rtl/mem_access_pkg.sv | 56 +++++
 rtl/mem_access_unit_load_extract.sv | 40 ++++
 rtl/mem_access_unit.sv | 153 +++++++++++++++
 tb/tb_mem_access_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit.
//   funct3 encodings, FSM state type, bus request payload, and
//   helpers for alignment checking and store-lane formatting.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_req_t;

  // funct3[1:0] selects size: 00 byte, 01 halfword, anything else word.
  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 1'b1;
      2'b01:   return ~a[0];
      default: return (a == 2'b00);
    endcase
  endfunction

  // Word-aligned address, lane-replicated data and byte enables for one access.
  function automatic bus_req_t build_req(input logic [31:0] addr, input logic we,
                                         input logic [2:0] f3, input logic [31:0] rs2);
    bus_req_t r;
    r.addr = {addr[31:2], 2'b00};
    r.we   = we;
    case (f3[1:0])
      2'b00: begin
        r.wdata = {4{rs2[7:0]}};
        r.be    = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        r.wdata = {2{rs2[15:0]}};
        r.be    = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        r.wdata = rs2;
        r.be    = 4'b1111;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extract.sv
// Combinational load-data extractor.
//   i_rdata   : raw 32-bit read word
//   i_addr_lo : byte offset latched with the request
//   i_funct3  : access size/sign
//   o_value   : sign/zero-extended load value
module load_extract
  import mem_access_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select: byte at addr[1:0], halfword at addr[1].
  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    case (i_funct3)
      F3_B:    o_value = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_value = {24'd0, w_byte};
      F3_H:    o_value = {{16{w_half[15]}}, w_half};
      F3_HU:   o_value = {16'd0, w_half};
      F3_W:    o_value = i_rdata;
      default: o_value = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: request/ready bus handshake,
// store lane alignment, load extraction and pipeline stall generation.
//   memRead/memWrite/funct3/ALUResult/RegData2 : MEM-stage access inputs
//   bus_*                                      : registered data-memory bus request
//   bus_ready/bus_rdata                        : bus completion and read data
//   mem_stall                                  : combinational pipeline hold
//   memReadRst_MEMWB_out                       : registered extended load value
//   mem_fault                                  : one-cycle misalign/timeout pulse
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memRead_EXMEM_out,
  input  logic        memWrite_EXMEM_out,
  input  logic [2:0]  funct3_EXMEM_out,
  input  logic [31:0] ALUResult_EXMEM_out,
  input  logic [31:0] RegData2_after_forward_M,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic        mem_stall,
  output logic [31:0] memReadRst_MEMWB_out,
  output logic        mem_fault
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

  state_t           r_state;
  state_t           w_state_nxt;
  bus_req_t         r_req;
  bus_req_t         w_req_new;
  logic             r_req_vld;
  logic [1:0]       r_addr_lo;
  logic [2:0]       r_f3;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_result;
  logic             r_fault;

  logic        w_access;
  logic        w_aligned;
  logic        w_timeout;
  logic        w_start;
  logic        w_done;
  logic        w_cnt_inc;
  logic        w_res_cap;
  logic        w_res_zero;
  logic        w_fault_nxt;
  logic [31:0] w_load_val;

  assign w_access  = memRead_EXMEM_out | memWrite_EXMEM_out;
  assign w_aligned = is_aligned(funct3_EXMEM_out, ALUResult_EXMEM_out[1:0]);
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
  // A simultaneous read+write is performed as a write.
  assign w_req_new = build_req(ALUResult_EXMEM_out, memWrite_EXMEM_out,
                               funct3_EXMEM_out, RegData2_after_forward_M);

  load_extract u_load_extract (
    .i_rdata   (bus_rdata),
    .i_addr_lo (r_addr_lo),
    .i_funct3  (r_f3),
    .o_value   (w_load_val)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_cnt_inc   = 1'b0;
    w_res_cap   = 1'b0;
    w_res_zero  = 1'b0;
    w_fault_nxt = 1'b0;
    mem_stall   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_access) begin
          if (w_aligned) begin
            w_start     = 1'b1;
            mem_stall   = 1'b1;
            w_state_nxt = BUSY;
          end else begin
            w_fault_nxt = 1'b1;
            w_res_zero  = ~memWrite_EXMEM_out;
          end
        end
      end
      BUSY: begin
        if (bus_ready) begin
          // Stall drops now so the pipeline advances on the capture edge.
          w_done      = 1'b1;
          w_res_cap   = ~r_req.we;
          w_state_nxt = IDLE;
        end else if (w_timeout) begin
          w_done      = 1'b1;
          w_fault_nxt = 1'b1;
          w_res_zero  = ~r_req.we;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_inc   = 1'b1;
          mem_stall   = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request registers, timeout counter, result and fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req     <= '0;
      r_req_vld <= 1'b0;
      r_addr_lo <= 2'd0;
      r_f3      <= 3'd0;
      r_cnt     <= '0;
      r_result  <= 32'd0;
      r_fault   <= 1'b0;
    end else begin
      r_req_vld <= (w_state_nxt == BUSY);
      r_fault   <= w_fault_nxt;
      if (w_start) begin
        r_req     <= w_req_new;
        r_addr_lo <= ALUResult_EXMEM_out[1:0];
        r_f3      <= funct3_EXMEM_out;
      end
      if (w_done)         r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);
      if (w_res_cap)       r_result <= w_load_val;
      else if (w_res_zero) r_result <= 32'd0;
    end
  end

  assign bus_req              = r_req_vld;
  assign bus_we               = r_req.we;
  assign bus_addr             = r_req.addr;
  assign bus_wdata            = r_req.wdata;
  assign bus_be               = r_req.be;
  assign memReadRst_MEMWB_out = r_result;
  assign mem_fault            = r_fault;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table followed by
// randomized accesses checked against an arithmetic reference model, plus an
// asynchronous reset during an outstanding access.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_rd, mem_wr;
  logic [2:0]  f3;
  logic [31:0] alu_addr, rs2;
  logic        bus_req, bus_we, bus_ready, mem_stall, mem_fault;
  logic [31:0] bus_addr, bus_wdata, bus_rdata, result;
  logic [3:0]  bus_be;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_result = 32'd0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYC(TO)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .memRead_EXMEM_out        (mem_rd),
    .memWrite_EXMEM_out       (mem_wr),
    .funct3_EXMEM_out         (f3),
    .ALUResult_EXMEM_out      (alu_addr),
    .RegData2_after_forward_M (rs2),
    .bus_req                  (bus_req),
    .bus_we                   (bus_we),
    .bus_addr                 (bus_addr),
    .bus_wdata                (bus_wdata),
    .bus_be                   (bus_be),
    .bus_ready                (bus_ready),
    .bus_rdata                (bus_rdata),
    .mem_stall                (mem_stall),
    .memReadRst_MEMWB_out     (result),
    .mem_fault                (mem_fault)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    int          wait_n;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          chk_wd;
    logic [31:0] res;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned m_size(input logic [2:0] fn);
    case (fn)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit m_aligned(input logic [2:0] fn, input logic [31:0] a);
    return (a % m_size(fn)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] fn, input logic [31:0] a);
    int unsigned off = a % 4;
    if (m_size(fn) == 1) return 4'(1 << off);
    if (m_size(fn) == 2) return (off >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] fn, input logic [31:0] d);
    if (m_size(fn) == 1) return (d & 32'hFF) * 32'h01010101;
    if (m_size(fn) == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_extract(input logic [2:0] fn, input logic [31:0] a,
                                            input logic [31:0] d);
    int unsigned off = a % 4;
    logic [31:0] v;
    bit sgn = (fn < 3'd4);
    if (m_size(fn) == 1) begin
      v = (d >> (8 * off)) & 32'hFF;
      if (sgn && v >= 32'd128) v = v + 32'hFFFFFF00;
      return v;
    end
    if (m_size(fn) == 2) begin
      v = (d >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
      if (sgn && v >= 32'd32768) v = v + 32'hFFFF0000;
      return v;
    end
    return d;
  endfunction

  task automatic drive_idle();
    mem_rd = 1'b0; mem_wr = 1'b0; f3 = 3'd0; alu_addr = $urandom; rs2 = $urandom;
  endtask

  // One pipeline access: inputs held while stalled, released when the stall drops.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] fn,
                            input logic [31:0] a, input logic [31:0] d, input int wait_n,
                            input logic [31:0] rdata, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd, input bit chk_wd,
                            input logic [31:0] exp_res);
    int stalls = 0;
    bit al = m_aligned(fn, a);
    bit to = (wait_n >= TO);
    logic [31:0] exp_addr = {a[31:2], 2'b00};
    @(posedge clk); #1;
    mem_rd = rd; mem_wr = wr; f3 = fn; alu_addr = a; rs2 = d;
    bus_ready = 1'b0; bus_rdata = $urandom;
    @(negedge clk);
    if (mem_stall) stalls++;
    check("req_low_detect", bus_req, 1'b0);
    if (al) begin
      for (int k = 0; k < TO; k++) begin
        @(posedge clk); #1;
        bus_ready = (k == wait_n);
        bus_rdata = (k == wait_n) ? rdata : $urandom;
        @(negedge clk);
        if (mem_stall) stalls++;
        check("busy_req", bus_req, 1'b1);
        check("busy_addr", bus_addr, exp_addr);
        check("busy_we", bus_we, wr);
        check("busy_be", bus_be, exp_be);
        if (chk_wd) check("busy_wdata", bus_wdata, exp_wd);
        if (k == wait_n) break;
      end
    end
    @(posedge clk); #1;
    drive_idle();
    bus_ready = 1'($urandom % 2);   // ready while idle must be ignored
    bus_rdata = $urandom;
    @(negedge clk);
    check("after_req", bus_req, 1'b0);
    check("after_stall", mem_stall, 1'b0);
    check("after_fault", mem_fault, (!al || to) ? 1'b1 : 1'b0);
    check("result", result, exp_res);
    check("stall_cycles", stalls, !al ? 0 : (to ? TO : wait_n + 1));
    @(posedge clk); #1;
    bus_ready = 1'b0;
    @(negedge clk);
    check("fault_pulse_end", mem_fault, 1'b0);
    check("result_hold", result, exp_res);
  endtask

  initial begin
    // rd wr f3 addr rs2 wait rdata be wdata chk_wd res
    tbl[0]  = '{1'b0, 1'b1, 3'b000, 32'h1003, 32'h000000A5, 0, 32'h0, 4'b1000, 32'hA5A5A5A5, 1'b1, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 3'b000, 32'h2002, 32'h0, 0, 32'h12F03456, 4'b0100, 32'h0, 1'b0, 32'hFFFFFFF0};
    tbl[2]  = '{1'b1, 1'b0, 3'b100, 32'h2002, 32'h0, 0, 32'h12F03456, 4'b0100, 32'h0, 1'b0, 32'h000000F0};
    tbl[3]  = '{1'b1, 1'b0, 3'b001, 32'h2002, 32'h0, 0, 32'h80011234, 4'b1100, 32'h0, 1'b0, 32'hFFFF8001};
    tbl[4]  = '{1'b1, 1'b0, 3'b101, 32'h2002, 32'h0, 0, 32'h80011234, 4'b1100, 32'h0, 1'b0, 32'h00008001};
    tbl[5]  = '{1'b1, 1'b0, 3'b010, 32'h2000, 32'h0, 3, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0, 32'hDEADBEEF};
    tbl[6]  = '{1'b0, 1'b1, 3'b001, 32'h4006, 32'hCAFEBABE, 1, 32'h0, 4'b1100, 32'hBABEBABE, 1'b1, 32'hDEADBEEF};
    tbl[7]  = '{1'b1, 1'b0, 3'b010, 32'h3002, 32'h0, 0, 32'h0, 4'b0000, 32'h0, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 1'b1, 3'b010, 32'h4000, 32'h11223344, 9, 32'h0, 4'b1111, 32'h11223344, 1'b1, 32'h0};
    tbl[9]  = '{1'b1, 1'b0, 3'b010, 32'h5000, 32'h0, 1, 32'h0BADF00D, 4'b1111, 32'h0, 1'b0, 32'h0BADF00D};
    tbl[10] = '{1'b1, 1'b1, 3'b000, 32'h6001, 32'h0000007F, 0, 32'h0, 4'b0010, 32'h7F7F7F7F, 1'b1, 32'h0BADF00D};
    tbl[11] = '{1'b0, 1'b1, 3'b001, 32'h7001, 32'h12345678, 0, 32'h0, 4'b0000, 32'h0, 1'b0, 32'h0BADF00D};
    tbl[12] = '{1'b1, 1'b0, 3'b000, 32'h2001, 32'h0, 2, 32'h00008000, 4'b0010, 32'h0, 1'b0, 32'hFFFFFF80};
    tbl[13] = '{1'b1, 1'b0, 3'b010, 32'h8000, 32'h0, 20, 32'h0, 4'b1111, 32'h0, 1'b0, 32'h0};
    tbl[14] = '{1'b1, 1'b0, 3'b011, 32'h9004, 32'h0, 0, 32'h55AA33CC, 4'b1111, 32'h0, 1'b0, 32'h55AA33CC};

    rst_n = 1'b0; drive_idle(); bus_ready = 1'b0; bus_rdata = 32'd0;
    #12;
    check("rst_req", bus_req, 1'b0);
    check("rst_we", bus_we, 1'b0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);
    check("rst_be", bus_be, 4'd0);
    check("rst_result", result, 32'd0);
    check("rst_fault", mem_fault, 1'b0);
    check("rst_stall", mem_stall, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    foreach (tbl[i]) begin
      run_access(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].rs2, tbl[i].wait_n,
                 tbl[i].rdata, tbl[i].be, tbl[i].wdata, tbl[i].chk_wd, tbl[i].res);
      m_result = tbl[i].res;
    end

    for (int n = 0; n < 60; n++) begin
      logic rd, wr;
      logic [2:0] fn;
      logic [31:0] a, d, rdata, er;
      int w;
      logic [2:0] f3s[7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
      int sel = $urandom_range(1, 3);
      rd = sel[0]; wr = sel[1];
      fn = f3s[$urandom_range(0, 6)];
      a = $urandom; d = $urandom; rdata = $urandom;
      w = $urandom_range(0, 5);
      er = m_result;
      if (!wr && !m_aligned(fn, a)) er = 32'd0;
      else if (!wr && w >= TO)      er = 32'd0;
      else if (!wr)                 er = m_extract(fn, a, rdata);
      run_access(rd, wr, fn, a, d, w, rdata, m_be(fn, a), m_wdata(fn, d), wr, er);
      m_result = er;
    end

    // Async reset while an access is outstanding.
    @(posedge clk); #1;
    mem_rd = 1'b1; mem_wr = 1'b0; f3 = 3'b010; alu_addr = 32'h0000A000; bus_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_req", bus_req, 1'b1);
    #2;
    rst_n = 1'b0; drive_idle();
    #1;
    check("midrst_req", bus_req, 1'b0);
    check("midrst_addr", bus_addr, 32'd0);
    check("midrst_be", bus_be, 4'd0);
    check("midrst_we", bus_we, 1'b0);
    check("midrst_wdata", bus_wdata, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_stall", mem_stall, 1'b0);
    check("midrst_fault", mem_fault, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req", bus_req, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
